// File: rtl/coeff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coeff_pkg
// Description : Shared constants and state encoding for the coefficient
//               loader (datapath and bench).
// Revision    : 1.0 - initial release
// ============================================================================
package coeff_pkg;

  // Default coefficient word width and tap count
  localparam int COEFF_BITS = 32;
  localparam int COEFF_CGES = 49;
  // Index / count field width: must be able to hold the value CGES itself
  localparam int COEFF_IW   = $clog2(COEFF_CGES + 1);

  // Loader session state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/coeff_bank_regs.sv
`default_nettype none
// ============================================================================
// Module      : coeff_bank_regs
// Description : DEPTH x BITS register bank, one write port, synchronous
//               clear, full array exposed in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_bank_regs
  import coeff_pkg::*;
#(
  parameter int BITS  = COEFF_BITS,
  parameter int DEPTH = COEFF_CGES,
  parameter int AW    = COEFF_IW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [BITS-1:0]             wdata,
  output logic [DEPTH-1:0][BITS-1:0]  bank
);

  logic [DEPTH-1:0][BITS-1:0] bank_q;
  logic [DEPTH-1:0][BITS-1:0] bank_d;

  // Decode the write address per entry; addresses >= DEPTH write nothing
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == AW'(i))) begin
        bank_d[i] = wdata;
      end
    end
  end

  // Bank storage with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign bank = bank_q;

endmodule
`default_nettype wire

// File: rtl/coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : coeff_loader
// Description : Accepts a valid/ready stream of signed coefficients, stores
//               them in a CGES-entry bank and builds the per-tap enable mask.
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_loader
  import coeff_pkg::*;
#(
  parameter int BITS = COEFF_BITS,
  parameter int CGES = COEFF_CGES,
  parameter int IW   = $clog2(CGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IW-1:0]              count,
  input  logic                       s_valid,
  input  logic [BITS-1:0]            s_data,
  output logic                       s_ready,
  output logic [CGES-1:0][BITS-1:0]  coeff_bank,
  output logic [CGES-1:1]            cges,
  output logic                       busy,
  output logic                       done
);

  localparam logic [IW-1:0] N_MAX = IW'(CGES);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [IW-1:0]   n_q,     n_d;
  logic [CGES-1:1] cges_q,  cges_d;
  logic [IW-1:0]   n_req;
  logic            bank_we;

  // Oversized requests are silently clamped to the bank depth
  assign n_req = (count > N_MAX) ? N_MAX : count;

  // Next-state, index, length and mask update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    cges_d  = cges_q;
    bank_we = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = n_req;
          idx_d   = '0;
          cges_d  = '0;
          state_d = (n_req == '0) ? DONE : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // start is deliberately not looked at while a session is running
        if (s_valid) begin
          bank_we = 1'b1;
          // Tap 0 has no mask bit: it is always enabled downstream
          if (idx_q != '0) begin
            cges_d[idx_q] = 1'b1;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == (n_q - 1'b1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any session in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      cges_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cges_q  <= cges_d;
    end
  end

  coeff_bank_regs #(
    .BITS  (BITS),
    .DEPTH (CGES),
    .AW    (IW)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we),
    .waddr (idx_q),
    .wdata (s_data),
    .bank  (coeff_bank)
  );

  // Moore outputs decoded from state only
  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == LOAD);
  assign done    = (state_q == DONE);
  assign cges    = cges_q;

endmodule
`default_nettype wire
